// File: rtl/sig_detect.sv
// -----------------------------------------------------------------------------
// sig_detect: edge-triggered delay-and-gate generator.
//
// A rising edge on B, seen while idle, arms the block. After `delay` clock
// cycles it drives one pulse on `signal` that is `duration` cycles wide.
// Edges that arrive while a delay or pulse is in progress are ignored.
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset (priority over everything)
//   B        in   trigger input, already synchronous to clk
//   duration in   [CNT_W-1:0] pulse width in cycles (0 = no pulse)
//   delay    in   [CNT_W-1:0] cycles from edge detection to pulse start
//   signal   out  registered gate output
// -----------------------------------------------------------------------------
module sig_detect #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             B,
  input  logic [CNT_W-1:0] duration,
  input  logic [CNT_W-1:0] delay,
  output logic             signal
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DELAY = 2'd1;
  localparam logic [1:0] S_PULSE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_dur;
  logic             r_b_q;
  logic             r_signal;
  logic             w_edge;

  assign w_edge = B & ~r_b_q;
  assign signal = r_signal;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= CNT_ZERO;
      r_dur    <= CNT_ZERO;
      // History starts high so a B held high through reset release is not
      // mistaken for a fresh edge.
      r_b_q    <= 1'b1;
      r_signal <= 1'b0;
    end else begin
      r_b_q <= B;
      case (r_state)
        S_IDLE: begin
          r_signal <= 1'b0;
          if (w_edge) begin
            // Capture the duration now so later input changes cannot
            // stretch or shorten a pulse already scheduled.
            r_dur <= duration;
            if (delay != CNT_ZERO) begin
              r_state <= S_DELAY;
              r_cnt   <= delay - CNT_ONE;
            end else if (duration != CNT_ZERO) begin
              r_state  <= S_PULSE;
              r_cnt    <= duration - CNT_ONE;
              r_signal <= 1'b1;
            end
          end
        end
        S_DELAY: begin
          if (r_cnt == CNT_ZERO) begin
            // A zero-width request still consumes the full delay.
            if (r_dur != CNT_ZERO) begin
              r_state  <= S_PULSE;
              r_cnt    <= r_dur - CNT_ONE;
              r_signal <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        S_PULSE: begin
          if (r_cnt == CNT_ZERO) begin
            r_state  <= S_IDLE;
            r_signal <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_signal <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sig_detect.sv
module tb_sig_detect;

  logic       clk;
  logic       rst;
  logic       B;
  logic [3:0] duration;
  logic [3:0] delay;
  logic       signal;

  int checks;
  int errors;
  int cyc_idx;
  string tag;
  bit exp_q[$];

  typedef struct {
    int d;
    int w;
    int hold;
  } vec_t;

  vec_t tbl[7];

  sig_detect #(.CNT_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .B        (B),
    .duration (duration),
    .delay    (delay),
    .signal   (signal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected signal for `total` cycles; high on cycle indices
  // [start, start+width), where index 0 is the cycle B is first driven high.
  task automatic push_pulse(input int start, input int width, input int total);
    for (int i = 0; i < total; i++)
      exp_q.push_back((i >= start) && (i < start + width));
  endtask

  task automatic push_zeros(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(1'b0);
  endtask

  // One clock: drive inputs after the falling edge, check #1 after the rise.
  task automatic cyc(input logic b, input logic r);
    bit e;
    @(negedge clk);
    B   = b;
    rst = r;
    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s cyc=%0d scoreboard empty, signal=%b", tag, cyc_idx, signal);
    end else begin
      e = exp_q.pop_front();
      if (signal !== e) begin
        errors++;
        $display("FAIL %s cyc=%0d signal=%b expected=%b", tag, cyc_idx, signal, e);
      end
    end
    cyc_idx++;
  endtask

  task automatic idle2();
    push_zeros(2);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    cyc_idx = 0;
  endtask

  initial begin
    logic [13:0] pat;
    checks  = 0;
    errors  = 0;
    cyc_idx = 0;
    rst      = 1'b1;
    B        = 1'b1;
    delay    = 4'd0;
    duration = 4'd0;

    tbl[0] = '{d: 3,  w: 1,  hold: 1};
    tbl[1] = '{d: 0,  w: 4,  hold: 1};
    tbl[2] = '{d: 15, w: 15, hold: 2};
    tbl[3] = '{d: 1,  w: 1,  hold: 6};
    tbl[4] = '{d: 0,  w: 0,  hold: 1};
    tbl[5] = '{d: 5,  w: 0,  hold: 1};
    tbl[6] = '{d: 0,  w: 1,  hold: 1};

    // Reset with B high, then B held high for 20 cycles: no pulse.
    tag = "reset";
    push_zeros(2);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    tag = "held_high";
    cyc_idx = 0;
    delay    = 4'd1;
    duration = 4'd2;
    push_zeros(20);
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0);
    // Low for one cycle, then high and held: exactly one pulse.
    tag = "after_low";
    push_zeros(1);
    cyc(1'b0, 1'b0);
    cyc_idx = 0;
    push_pulse(1, 2, 8);
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0);

    // Table-driven single triggers; inputs scrambled after capture.
    for (int t = 0; t < 7; t++) begin
      $sformat(tag, "vec%0d_d%0d_w%0d", t, tbl[t].d, tbl[t].w);
      delay    = 4'(tbl[t].d);
      duration = 4'(tbl[t].w);
      idle2();
      push_pulse(tbl[t].d, tbl[t].w, tbl[t].d + tbl[t].w + tbl[t].hold + 3);
      cyc(1'b1, 1'b0);
      delay    = ~delay;
      duration = ~duration;
      for (int i = 1; i < tbl[t].hold; i++) cyc(1'b1, 1'b0);
      for (int i = tbl[t].hold; i < tbl[t].d + tbl[t].w + tbl[t].hold + 3; i++)
        cyc(1'b0, 1'b0);
    end

    // Non-retriggerable: edges at 2 (delay), 5 (pulse), 8 (pulse end cycle).
    tag = "retrig";
    delay    = 4'd3;
    duration = 4'd5;
    idle2();
    pat = 14'b00000100100101;
    push_pulse(3, 5, 14);
    for (int i = 0; i < 14; i++) cyc(pat[i], 1'b0);
    tag = "retrig_again";
    cyc_idx = 0;
    push_pulse(3, 5, 10);
    cyc(1'b1, 1'b0);
    for (int i = 1; i < 10; i++) cyc(1'b0, 1'b0);

    // Zero duration consumes the delay; an edge 3 cycles later is accepted.
    tag = "zero_dur";
    delay    = 4'd2;
    duration = 4'd0;
    idle2();
    push_pulse(5, 2, 10);
    cyc(1'b1, 1'b0);
    duration = 4'd2;
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    for (int i = 4; i < 10; i++) cyc(1'b0, 1'b0);

    // Reset four cycles into an 8-cycle pulse aborts it for good.
    tag = "rst_mid";
    delay    = 4'd2;
    duration = 4'd8;
    idle2();
    push_pulse(2, 4, 16);
    cyc(1'b1, 1'b0);
    for (int i = 1; i < 6; i++) cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    for (int i = 7; i < 16; i++) cyc(1'b0, 1'b0);
    tag = "rst_fresh";
    cyc_idx = 0;
    push_pulse(2, 8, 13);
    cyc(1'b1, 1'b0);
    for (int i = 1; i < 13; i++) cyc(1'b0, 1'b0);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover scoreboard entries=%0d expected=0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the bench always ends on its own.
  initial begin
    #200000;
    $display("FAIL timeout reached, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
